// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, weight RAM map and FSM states for the NN training datapath
package nn_pkg;

  typedef logic signed [9:0] weight_t;
  typedef logic [9:0]        act_t;

  localparam logic [6:0] W_BASE_OUT0 = 7'd50;
  localparam logic [6:0] W_BASE_OUT1 = 7'd55;
  localparam logic [6:0] W_BASE_OUT2 = 7'd60;

  localparam int N_HID = 5;
  localparam int N_OUT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CALC,
    S_WRITE,
    S_DONE
  } wu_state_t;

endpackage

// File: rtl/weight_step_alu.sv
// rtl/weight_step_alu.sv - w_new = sat(w -/+ (delta*out >> (10+LR_SHIFT))), purely combinational
module weight_step_alu
  import nn_pkg::*;
#(
  parameter int LR_SHIFT = 3
) (
  input  logic [9:0] i_w,
  input  logic [9:0] i_delta_mag,
  input  logic       i_delta_sign,
  input  logic [9:0] i_out_cal,
  output logic [9:0] o_w_new
);

  logic [19:0]        w_prod;
  logic [9:0]         w_step;
  logic signed [11:0] w_w_ext;
  logic signed [11:0] w_sum;

  assign w_prod  = {10'd0, i_delta_mag} * {10'd0, i_out_cal};
  // Q2.7 x Q0.10 is Q2.17; dropping 10 bits lands back on Q2.7 before eta scaling
  assign w_step  = 10'(w_prod >> (10 + LR_SHIFT));
  assign w_w_ext = {{2{i_w[9]}}, i_w};
  assign w_sum   = i_delta_sign ? (w_w_ext + {2'b00, w_step})
                                : (w_w_ext - {2'b00, w_step});

  always_comb begin
    if (w_sum > 12'sd511)
      o_w_new = 10'b01_1111_1111;
    else if (w_sum < -12'sd512)
      o_w_new = 10'b10_0000_0000;
    else
      o_w_new = w_sum[9:0];
  end

endmodule

// File: rtl/weight_update.sv
// rtl/weight_update.sv - read-modify-write update of the 15 output-layer weights
// Four cycles per weight (READ, WAIT, CALC, WRITE) followed by a one-cycle DONE.
module weight_update
  import nn_pkg::*;
#(
  parameter int LR_SHIFT = 3
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [N_OUT*10-1:0]    i_delta_mag,
  input  logic [N_OUT-1:0]       i_delta_sign,
  input  logic [N_HID*10-1:0]    i_out_cal,
  output logic [6:0]             o_ram_addr,
  output logic                   o_ram_we,
  output logic [9:0]             o_ram_wdata,
  input  logic [9:0]             i_ram_rdata,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [2:0] LAST_I = 3'(N_HID - 1);
  localparam logic [1:0] LAST_N = 2'(N_OUT - 1);

  wu_state_t        r_state, w_next;
  logic [1:0]       r_n;
  logic [2:0]       r_i;
  logic [9:0]       r_dm [N_OUT];
  logic [N_OUT-1:0] r_ds;
  act_t             r_oc [N_HID];
  logic [9:0]       r_w, r_w_new, w_alu;
  logic [6:0]       w_base, w_addr;

  weight_step_alu #(.LR_SHIFT(LR_SHIFT)) u_alu (
    .i_w          (r_w),
    .i_delta_mag  (r_dm[r_n]),
    .i_delta_sign (r_ds[r_n]),
    .i_out_cal    (r_oc[r_i]),
    .o_w_new      (w_alu)
  );

  always_comb begin
    case (r_n)
      2'd1:    w_base = W_BASE_OUT1;
      2'd2:    w_base = W_BASE_OUT2;
      default: w_base = W_BASE_OUT0;
    endcase
  end

  assign w_addr = w_base + {4'd0, r_i};

  // Outputs decode straight from state so a reset drops the write strobe without waiting for a clock
  always_comb begin
    w_next      = r_state;
    o_ram_addr  = 7'd0;
    o_ram_we    = 1'b0;
    o_ram_wdata = 10'd0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_READ;
      end
      S_READ: begin
        o_ram_addr = w_addr;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        o_ram_addr = w_addr;
        w_next     = S_CALC;
      end
      S_CALC: begin
        o_ram_addr = w_addr;
        w_next     = S_WRITE;
      end
      S_WRITE: begin
        o_ram_addr  = w_addr;
        o_ram_we    = 1'b1;
        o_ram_wdata = r_w_new;
        w_next      = (r_i == LAST_I && r_n == LAST_N) ? S_DONE : S_READ;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_n     <= 2'd0;
      r_i     <= 3'd0;
      r_ds    <= '0;
      r_w     <= 10'd0;
      r_w_new <= 10'd0;
      for (int k = 0; k < N_OUT; k++) r_dm[k] <= 10'd0;
      for (int k = 0; k < N_HID; k++) r_oc[k] <= 10'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_n  <= 2'd0;
            r_i  <= 3'd0;
            r_ds <= i_delta_sign;
            for (int k = 0; k < N_OUT; k++) r_dm[k] <= i_delta_mag[k*10 +: 10];
            for (int k = 0; k < N_HID; k++) r_oc[k] <= i_out_cal[k*10 +: 10];
          end
        end
        S_WAIT:  r_w     <= i_ram_rdata;
        S_CALC:  r_w_new <= w_alu;
        S_WRITE: begin
          if (r_i != LAST_I) begin
            r_i <= r_i + 3'd1;
          end else if (r_n != LAST_N) begin
            r_i <= 3'd0;
            r_n <= r_n + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// tb/tb_weight_update.sv - directed self-checking bench for weight_update
module tb_weight_update;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start2, start0;
  logic [29:0] dm;
  logic [2:0]  ds;
  logic [49:0] oc;
  logic [6:0]  addr2, addr0;
  logic        we2, we0, busy2, busy0, done2, done0;
  logic [9:0]  wd2, wd0, rd2, rd0;

  logic signed [9:0] mem2 [0:127];
  logic signed [9:0] mem0 [0:127];
  logic        pre_we2, pre_we0;
  logic [6:0]  pre_addr;
  logic [9:0]  pre_data;

  logic [6:0]  log_addr [$];
  logic [9:0]  log_data [$];

  int n_assert = 0;
  int n_fail   = 0;

  int exp1 [15] = '{80, 95, 67, 64, 95, 32, 1, 58, 64, 2, 72, 79, 65, 64, 79};

  weight_update #(.LR_SHIFT(2)) u_dut2 (
    .i_clock(clk), .i_rst(rst), .i_start(start2),
    .i_delta_mag(dm), .i_delta_sign(ds), .i_out_cal(oc),
    .o_ram_addr(addr2), .o_ram_we(we2), .o_ram_wdata(wd2), .i_ram_rdata(rd2),
    .o_busy(busy2), .o_done(done2)
  );

  weight_update #(.LR_SHIFT(0)) u_dut0 (
    .i_clock(clk), .i_rst(rst), .i_start(start0),
    .i_delta_mag(dm), .i_delta_sign(ds), .i_out_cal(oc),
    .o_ram_addr(addr0), .o_ram_we(we0), .o_ram_wdata(wd0), .i_ram_rdata(rd0),
    .o_busy(busy0), .o_done(done0)
  );

  always @(posedge clk) begin
    if (pre_we2) mem2[pre_addr] <= pre_data;
    else if (we2) mem2[addr2] <= wd2;
    rd2 <= mem2[addr2];
  end

  always @(posedge clk) begin
    if (pre_we0) mem0[pre_addr] <= pre_data;
    else if (we0) mem0[addr0] <= wd0;
    rd0 <= mem0[addr0];
  end

  always @(negedge clk) begin
    if (we2) begin
      log_addr.push_back(addr2);
      log_data.push_back(wd2);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input bit sel, input int a, input int d);
    pre_addr = 7'(a);
    pre_data = 10'(d);
    if (sel) pre_we0 = 1'b1; else pre_we2 = 1'b1;
    @(negedge clk);
    pre_we0 = 1'b0;
    pre_we2 = 1'b0;
  endtask

  task automatic fill(input bit sel, input int d);
    for (int j = 0; j < 15; j++) poke(sel, 50 + j, d);
  endtask

  task automatic run(input bit sel, input int rs1, input int rs2, output int cyc, output bit busy_ok);
    int k;
    cyc = 0;
    busy_ok = 1'b1;
    k = 1;
    if (sel) start0 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    while (k <= 80 && cyc == 0) begin
      if (!(sel ? busy0 : busy2)) busy_ok = 1'b0;
      if (sel ? done0 : done2) cyc = k;
      if (k == rs1 || k == rs2) begin
        start2 = 1'b1;
        dm = ~dm;
        ds = ~ds;
        oc = ~oc;
      end
      @(negedge clk);
      start2 = 1'b0;
      k++;
    end
  endtask

  initial begin
    int  cyc, base;
    bit  bok, found;
    rst = 1'b1; start2 = 1'b0; start0 = 1'b0;
    dm = '0; ds = '0; oc = '0;
    pre_we2 = 1'b0; pre_we0 = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);

    chk("reset_addr", addr2, 0);
    chk("reset_we", we2, 0);
    chk("reset_wdata", wd2, 0);
    chk("reset_busy", busy2, 0);
    chk("reset_done", done2, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic update, LR_SHIFT = 2, mixed signs and activations
    fill(0, 64);
    fill(1, 0);
    dm = {10'd64, 10'd256, 10'd128};
    ds = 3'b101;
    oc = {10'd1000, 10'd0, 10'd100, 10'd1023, 10'd512};
    base = log_addr.size();
    run(0, 0, 0, cyc, bok);
    chk("basic_done_cycle", cyc, 61);
    chk("basic_busy_throughout", bok, 1);
    chk("basic_done_one_cycle", done2, 0);
    chk("basic_idle_after", busy2, 0);
    chk("basic_write_count", log_addr.size() - base, 15);
    chk("basic_wdata_addr50", $signed(log_data[base]), 80);
    for (int j = 0; j < 15; j++) begin
      chk($sformatf("basic_order_%0d", j), log_addr[base + j], 50 + j);
      chk($sformatf("basic_ram_%0d", 50 + j), mem2[50 + j], exp1[j]);
    end

    // descent direction
    fill(0, 64);
    ds = 3'b000;
    base = log_addr.size();
    run(0, 0, 0, cyc, bok);
    chk("descent_done_cycle", cyc, 61);
    chk("descent_ram50", mem2[50], 48);
    chk("descent_ram55", mem2[55], 32);
    chk("descent_ram60", mem2[60], 56);
    chk("descent_write_count", log_addr.size() - base, 15);
    for (int j = 0; j < 15; j++)
      chk($sformatf("descent_order_%0d", j), log_addr[base + j], 50 + j);

    // saturation, LR_SHIFT = 0, step = 510
    poke(1, 55, 500);
    dm = {10'd0, 10'd511, 10'd0};
    ds = 3'b010;
    oc = {40'd0, 10'd1023};
    run(1, 0, 0, cyc, bok);
    chk("sat_pos_done_cycle", cyc, 61);
    chk("sat_pos_ram55", mem0[55], 511);
    chk("sat_pos_ram56_untouched", mem0[56], 0);
    poke(1, 55, -500);
    ds = 3'b000;
    run(1, 0, 0, cyc, bok);
    chk("sat_neg_ram55", mem0[55], -512);

    // zero step rewrites every weight unchanged
    for (int j = 0; j < 15; j++) poke(0, 50 + j, j * 37 - 250);
    dm = {10'd300, 10'd200, 10'd100};
    ds = 3'b010;
    oc = '0;
    base = log_addr.size();
    run(0, 0, 0, cyc, bok);
    chk("zero_done_cycle", cyc, 61);
    chk("zero_write_count", log_addr.size() - base, 15);
    for (int j = 0; j < 15; j++)
      chk($sformatf("zero_wdata_%0d", 50 + j), $signed(log_data[base + j]), j * 37 - 250);

    // start re-pulsed mid-pass and on done, inputs scrambled mid-pass
    fill(0, 64);
    dm = {10'd64, 10'd256, 10'd128};
    ds = 3'b101;
    oc = {10'd1000, 10'd0, 10'd100, 10'd1023, 10'd512};
    base = log_addr.size();
    run(0, 10, 61, cyc, bok);
    chk("hs_done_cycle", cyc, 61);
    chk("hs_busy_throughout", bok, 1);
    chk("hs_no_restart", busy2, 0);
    @(negedge clk);
    chk("hs_still_idle", busy2, 0);
    chk("hs_write_count", log_addr.size() - base, 15);
    for (int j = 0; j < 15; j++)
      chk($sformatf("hs_ram_%0d", 50 + j), mem2[50 + j], exp1[j]);

    // reset during the WRITE of address 57
    fill(0, 64);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (we2 && addr2 == 7'd57) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reached_write57", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_we_drop", we2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_done", done2, 0);
    chk("rst_addr", addr2, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = log_addr.size();
    run(0, 0, 0, cyc, bok);
    chk("rst_fresh_done_cycle", cyc, 61);
    chk("rst_fresh_busy", bok, 1);
    chk("rst_fresh_write_count", log_addr.size() - base, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
